// File: rtl/maxpool2x2_relu_stream_pkg.sv
// rtl/maxpool2x2_relu_stream_pkg.sv - FP32 field layout and helpers shared by the max-pool block
package maxpool2x2_relu_stream_pkg;

  localparam int FP_WIDTH    = 32;
  localparam int FP_EXP_W    = 8;
  localparam int FP_MAN_W    = 23;
  localparam int FP_SIGN_BIT = 31;
  localparam logic [FP_WIDTH-1:0] FP_ZERO = 32'h0000_0000;

  typedef struct packed {
    logic                sign;
    logic [FP_EXP_W-1:0] exp;
    logic [FP_MAN_W-1:0] man;
  } fp32_t;

  function automatic logic fp_is_zero(input fp32_t a);
    return ({a.exp, a.man} == '0);
  endfunction

  function automatic fp32_t fp_relu(input fp32_t a, input logic en);
    return (en && a.sign) ? fp32_t'(FP_ZERO) : a;
  endfunction

endpackage

// File: rtl/maxpool2x2_relu_stream_fp32_max.sv
// rtl/maxpool2x2_relu_stream_fp32_max.sv - combinational FP32 max; every tie, including +0 vs -0, returns i_a
module maxpool2x2_relu_stream_fp32_max
  import maxpool2x2_relu_stream_pkg::*;
(
  input  fp32_t i_a,
  input  fp32_t i_b,
  output fp32_t o_max
);

  always_comb begin
    o_max = i_a;
    if (fp_is_zero(i_a) && fp_is_zero(i_b)) begin
      o_max = i_a;
    end else if (i_a.sign != i_b.sign) begin
      o_max = i_a.sign ? i_b : i_a;
    end else if (!i_a.sign) begin
      o_max = ({i_b.exp, i_b.man} > {i_a.exp, i_a.man}) ? i_b : i_a;
    end else begin
      o_max = ({i_b.exp, i_b.man} < {i_a.exp, i_a.man}) ? i_b : i_a;
    end
  end

endmodule

// File: rtl/maxpool2x2_relu_stream.sv
// rtl/maxpool2x2_relu_stream.sv - streaming 2x2/stride-2 FP32 max-pool with optional fused ReLU
module maxpool2x2_relu_stream
  import maxpool2x2_relu_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int IMG_WIDTH  = 56,
  parameter int IMG_HEIGHT = 56,
  parameter bit RELU_EN    = 1'b1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  done
);

  localparam int CW       = $clog2(IMG_WIDTH);
  localparam int RW       = $clog2(IMG_HEIGHT);
  localparam int LB_DEPTH = IMG_WIDTH / 2;
  localparam int LBW      = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  fp32_t         r_hold;
  fp32_t         r_linebuf [LB_DEPTH];
  fp32_t         r_data_out;
  logic          r_valid_out;
  logic          r_done;

  fp32_t          w_x;
  fp32_t          w_max1;
  fp32_t          w_max2;
  logic           w_col_last;
  logic           w_row_last;
  logic [LBW-1:0] w_lb_idx;

  assign w_x        = fp_relu(fp32_t'(data_in), RELU_EN);
  assign w_col_last = (r_col == CW'(IMG_WIDTH - 1));
  assign w_row_last = (r_row == RW'(IMG_HEIGHT - 1));
  assign w_lb_idx   = LBW'(r_col >> 1);

  // Horizontal pair max, then vertical max against the pair stored from the row above.
  maxpool2x2_relu_stream_fp32_max u_max_h (
    .i_a   (r_hold),
    .i_b   (w_x),
    .o_max (w_max1)
  );

  maxpool2x2_relu_stream_fp32_max u_max_v (
    .i_a   (r_linebuf[w_lb_idx]),
    .i_b   (w_max1),
    .o_max (w_max2)
  );

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      r_col       <= '0;
      r_row       <= '0;
      r_hold      <= '0;
      r_data_out  <= '0;
      r_valid_out <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_valid_out <= 1'b0;
      r_done      <= 1'b0;
      if (valid_in) begin
        if (w_col_last) begin
          r_col <= '0;
          r_row <= w_row_last ? '0 : r_row + RW'(1);
        end else begin
          r_col <= r_col + CW'(1);
        end
        if (!r_col[0]) begin
          r_hold <= w_x;
        end else if (r_row[0]) begin
          r_data_out  <= w_max2;
          r_valid_out <= 1'b1;
          r_done      <= w_col_last && w_row_last;
        end
      end
    end
  end

  // Line buffer holds no reset: even rows always overwrite before odd rows read.
  always_ff @(posedge clk) begin
    if (!resetn && valid_in && r_col[0] && !r_row[0]) begin
      r_linebuf[w_lb_idx] <= w_max1;
    end
  end

  assign data_out  = DATA_WIDTH'(r_data_out);
  assign valid_out = r_valid_out;
  assign done      = r_done;

endmodule

// File: tb/tb_maxpool2x2_relu_stream.sv
// tb/tb_maxpool2x2_relu_stream.sv - directed table-driven bench for maxpool2x2_relu_stream at 4x4
module tb_maxpool2x2_relu_stream;

  typedef struct {
    logic        v;
    logic [31:0] x;
    logic        ev;
    logic        ed;
    logic [31:0] er;
    logic [31:0] ew;
  } vec_t;

  logic        clk = 1'b0;
  logic        resetn;
  logic        valid_in;
  logic [31:0] data_in;
  logic [31:0] dout_r, dout_w;
  logic        vout_r, vout_w, done_r, done_w;

  int checks   = 0;
  int failures = 0;

  logic [31:0] ramp [16];
  logic [31:0] ramp_out [4];
  logic [31:0] neg_out [4];
  vec_t        tbl [16];

  always #5 clk = ~clk;

  maxpool2x2_relu_stream #(
    .DATA_WIDTH (32), .IMG_WIDTH (4), .IMG_HEIGHT (4), .RELU_EN (1'b1)
  ) u_relu (
    .clk (clk), .resetn (resetn), .valid_in (valid_in), .data_in (data_in),
    .data_out (dout_r), .valid_out (vout_r), .done (done_r)
  );

  maxpool2x2_relu_stream #(
    .DATA_WIDTH (32), .IMG_WIDTH (4), .IMG_HEIGHT (4), .RELU_EN (1'b0)
  ) u_raw (
    .clk (clk), .resetn (resetn), .valid_in (valid_in), .data_in (data_in),
    .data_out (dout_w), .valid_out (vout_w), .done (done_w)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%08h required=%08h", name, act, exp);
    end
  endtask

  function automatic int slot(input int i);
    case (i)
      5:       return 0;
      7:       return 1;
      13:      return 2;
      15:      return 3;
      default: return -1;
    endcase
  endfunction

  // Drive at the falling edge, let the rising edge accept, sample at the next falling edge.
  task automatic step(input logic v, input logic [31:0] x, input logic ev, input logic ed,
                      input logic [31:0] er, input logic [31:0] ew, input string tag);
    valid_in = v;
    data_in  = v ? x : $urandom();
    @(posedge clk);
    @(negedge clk);
    check($sformatf("%s relu valid_out", tag), {31'b0, vout_r}, {31'b0, ev});
    check($sformatf("%s raw valid_out", tag),  {31'b0, vout_w}, {31'b0, ev});
    check($sformatf("%s relu done", tag),      {31'b0, done_r}, {31'b0, ed});
    check($sformatf("%s raw done", tag),       {31'b0, done_w}, {31'b0, ed});
    if (ev) begin
      check($sformatf("%s relu data_out", tag), dout_r, er);
      check($sformatf("%s raw data_out", tag),  dout_w, ew);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check($sformatf("%s relu data_out", tag),  dout_r, 32'h0);
    check($sformatf("%s relu valid_out", tag), {31'b0, vout_r}, 32'h0);
    check($sformatf("%s relu done", tag),      {31'b0, done_r}, 32'h0);
    check($sformatf("%s raw data_out", tag),   dout_w, 32'h0);
    check($sformatf("%s raw valid_out", tag),  {31'b0, vout_w}, 32'h0);
    check($sformatf("%s raw done", tag),       {31'b0, done_w}, 32'h0);
  endtask

  initial begin
    ramp = '{32'h3f800000, 32'h40000000, 32'h40400000, 32'h40800000,
             32'h40a00000, 32'h40c00000, 32'h40e00000, 32'h41000000,
             32'h41100000, 32'h41200000, 32'h41300000, 32'h41400000,
             32'h41500000, 32'h41600000, 32'h41700000, 32'h41800000};
    ramp_out = '{32'h40c00000, 32'h41000000, 32'h41600000, 32'h41800000};
    neg_out  = '{32'hbf800000, 32'hc0400000, 32'hc1100000, 32'hc1300000};
    for (int i = 0; i < 16; i++) begin
      tbl[i].v  = 1'b1;
      tbl[i].x  = ramp[i];
      tbl[i].ev = (slot(i) >= 0);
      tbl[i].ed = (i == 15);
      tbl[i].er = (slot(i) >= 0) ? ramp_out[slot(i)] : 32'h0;
      tbl[i].ew = tbl[i].er;
    end

    resetn   = 1'b1;
    valid_in = 1'b0;
    data_in  = 32'h0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    resetn = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 16; i++)
      step(tbl[i].v, tbl[i].x, tbl[i].ev, tbl[i].ed, tbl[i].er, tbl[i].ew, $sformatf("ramp[%0d]", i));

    for (int i = 0; i < 16; i++) begin
      step(tbl[i].v, tbl[i].x, tbl[i].ev, tbl[i].ed, tbl[i].er, tbl[i].ew, $sformatf("toggle[%0d]", i));
      step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, $sformatf("toggle_stall[%0d]", i));
    end

    for (int i = 0; i < 16; i++)
      step(1'b1, (i == 1) ? 32'hbf800000 : 32'hc0000000, slot(i) >= 0, i == 15,
           32'h0, (slot(i) == 0) ? 32'hbf800000 : 32'hc0000000, $sformatf("negframe[%0d]", i));

    for (int i = 0; i < 16; i++)
      step(tbl[i].v, tbl[i].x, tbl[i].ev, tbl[i].ed, tbl[i].er, tbl[i].ew, $sformatf("b2b_f0[%0d]", i));
    for (int i = 0; i < 16; i++)
      step(1'b1, ramp[i] | 32'h80000000, slot(i) >= 0, i == 15,
           32'h0, (slot(i) >= 0) ? neg_out[slot(i)] : 32'h0, $sformatf("b2b_f1[%0d]", i));

    for (int i = 0; i < 9; i++)
      step(tbl[i].v, tbl[i].x, tbl[i].ev, tbl[i].ed, tbl[i].er, tbl[i].ew, $sformatf("abort[%0d]", i));
    valid_in = 1'b1;
    data_in  = 32'h42000000;
    resetn   = 1'b1;
    #1;
    check_reset_outputs("midreset");
    @(negedge clk);
    check_reset_outputs("midreset_held");
    resetn   = 1'b0;
    valid_in = 1'b0;
    for (int i = 0; i < 16; i++)
      step(tbl[i].v, tbl[i].x, tbl[i].ev, tbl[i].ed, tbl[i].er, tbl[i].ew, $sformatf("after_reset[%0d]", i));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
